// File: rtl/systolic_pkg.sv
// Shared constants and types for the double-buffered systolic processing element.
package systolic_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ACC_W   = 40;
  localparam int DEF_MUL_LAT = 3;

  typedef logic signed [DEF_DATA_W-1:0] data_t;
  typedef logic signed [DEF_ACC_W-1:0]  acc_t;

  typedef struct packed {
    logic valid;
    logic load;
    logic swap;
  } pe_ctrl_t;

endpackage

// File: rtl/pe_mac_pipe.sv
// Multiply-accumulate with a MUL_LAT-deep result/valid pipeline that freezes while enable is low.
// Defining SYSTOLIC_PE_SAT_EN clamps the final add instead of letting it wrap.
module pe_mac_pipe
  import systolic_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     accept,
  input  logic signed [DATA_W-1:0] data,
  input  logic signed [DATA_W-1:0] weight,
  input  logic signed [ACC_W-1:0]  sum_in,
  output logic signed [ACC_W-1:0]  sum_out,
  output logic                     sum_valid
);

  logic signed [2*DATA_W-1:0] product;
  logic signed [ACC_W-1:0]    mac_result;
  logic [MUL_LAT-1:0]         vld_q;
  logic signed [ACC_W-1:0]    sum_q [MUL_LAT];

`ifdef SYSTOLIC_PE_SAT_EN
  logic signed [ACC_W:0] wide_sum;

  // One guard bit exposes overflow; differing top bits mean the true sum is out of range.
  always_comb begin
    product  = (2*DATA_W)'(data) * (2*DATA_W)'(weight);
    wide_sum = (ACC_W+1)'(sum_in) + (ACC_W+1)'(product);
    if (wide_sum[ACC_W] != wide_sum[ACC_W-1])
      mac_result = wide_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      mac_result = wide_sum[ACC_W-1:0];
  end
`else
  always_comb begin
    product    = (2*DATA_W)'(data) * (2*DATA_W)'(weight);
    mac_result = sum_in + ACC_W'(product);
  end
`endif

  // Stage data only moves with a valid token, so the last stage holds its value through bubbles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < MUL_LAT; i++) sum_q[i] <= '0;
    end else if (enable) begin
      vld_q[0] <= accept;
      if (accept) sum_q[0] <= mac_result;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) sum_q[i] <= sum_q[i-1];
      end
    end
  end

  assign sum_out   = sum_q[MUL_LAT-1];
  assign sum_valid = vld_q[MUL_LAT-1];

endmodule

// File: rtl/systolic_pe_db.sv
// Weight-stationary systolic PE with shadow/active double-buffered weights.
// Optional SYSTOLIC_PE_SAT_EN selects saturating accumulation in pe_mac_pipe.
module systolic_pe_db
  import systolic_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  input  logic signed [ACC_W-1:0]  in_sum,
  input  logic signed [DATA_W-1:0] w_in,
  input  logic                     w_load,
  input  logic                     w_swap,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_data_valid,
  output logic signed [ACC_W-1:0]  out_sum,
  output logic                     out_sum_valid,
  output logic signed [DATA_W-1:0] w_out,
  output logic                     w_load_out,
  output logic                     w_swap_out
);

  if (ACC_W < 2*DATA_W) begin : g_bad_acc_w
    $error("systolic_pe_db: ACC_W must be at least 2*DATA_W");
  end
  if (MUL_LAT < 1 || MUL_LAT > 8) begin : g_bad_mul_lat
    $error("systolic_pe_db: MUL_LAT must be within 1..8");
  end

  logic signed [DATA_W-1:0] data_q;
  logic signed [DATA_W-1:0] shadow_w;
  logic signed [DATA_W-1:0] active_w;
  pe_ctrl_t                 ctrl_q;
  logic                     accept;

  assign accept = enable & in_valid;

  // A same-cycle swap copies the pre-edge shadow, so load+swap moves old shadow to active.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= '0;
      shadow_w <= '0;
      active_w <= '0;
      ctrl_q   <= '0;
    end else if (enable) begin
      data_q <= in_data;
      ctrl_q <= '{valid: in_valid, load: w_load, swap: w_swap};
      if (w_load) shadow_w <= w_in;
      if (w_swap) active_w <= shadow_w;
    end
  end

  assign out_data       = data_q;
  assign out_data_valid = ctrl_q.valid;
  assign w_out          = shadow_w;
  assign w_load_out     = ctrl_q.load;
  assign w_swap_out     = ctrl_q.swap;

  pe_mac_pipe #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .MUL_LAT(MUL_LAT)
  ) u_mac (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .accept   (accept),
    .data     (in_data),
    .weight   (active_w),
    .sum_in   (in_sum),
    .sum_out  (out_sum),
    .sum_valid(out_sum_valid)
  );

endmodule

// File: tb/tb_systolic_pe_db.sv
// Directed self-checking bench for systolic_pe_db (DATA_W=16, ACC_W=40, MUL_LAT=3).
module tb_systolic_pe_db;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               enable;
  logic signed [15:0] in_data;
  logic               in_valid;
  logic signed [39:0] in_sum;
  logic signed [15:0] w_in;
  logic               w_load;
  logic               w_swap;
  logic signed [15:0] out_data;
  logic               out_data_valid;
  logic signed [39:0] out_sum;
  logic               out_sum_valid;
  logic signed [15:0] w_out;
  logic               w_load_out;
  logic               w_swap_out;

  int checks   = 0;
  int failures = 0;

  localparam logic signed [63:0] ACC_MAX = 64'sh0000_007F_FFFF_FFFF;
  localparam logic signed [63:0] ACC_MIN = -64'sh0000_0080_0000_0000;
`ifdef SYSTOLIC_PE_SAT_EN
  localparam logic signed [63:0] OVF_EXP = ACC_MAX;
`else
  localparam logic signed [63:0] OVF_EXP = ACC_MIN;
`endif

  systolic_pe_db dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_sum        (in_sum),
    .w_in          (w_in),
    .w_load        (w_load),
    .w_swap        (w_swap),
    .out_data      (out_data),
    .out_data_valid(out_data_valid),
    .out_sum       (out_sum),
    .out_sum_valid (out_sum_valid),
    .w_out         (w_out),
    .w_load_out    (w_load_out),
    .w_swap_out    (w_swap_out)
  );

  always #5 clk = ~clk;

  // Advance one clock edge, then settle 1 ns so inputs change and outputs are sampled off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic signed [63:0] obs,
                              input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic signed [15:0] d,
                                input logic signed [39:0] s, input logic signed [15:0] w,
                                input logic ld, input logic sw);
    in_valid = v;
    in_data  = d;
    in_sum   = s;
    w_in     = w;
    w_load   = ld;
    w_swap   = sw;
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    apply_stimulus(1'b0, 16'sd0, 40'sd0, 16'sd0, 1'b0, 1'b0);
    #3;
    check_output("reset_out_sum", out_sum, 0);
    check_output("reset_out_sum_valid", out_sum_valid, 0);
    check_output("reset_out_data_valid", out_data_valid, 0);
    check_output("reset_w_out", w_out, 0);
    step();
    step();
    reset_n = 1'b1;
    enable  = 1'b1;

    // Basic MAC: w=3, 5*3+10 = 25 three cycles after accept
    apply_stimulus(1'b0, 16'sd0, 40'sd0, 16'sd3, 1'b1, 1'b0);
    step();
    check_output("load_w_out", w_out, 3);
    check_output("load_w_load_out", w_load_out, 1);
    apply_stimulus(1'b0, 16'sd0, 40'sd0, 16'sd0, 1'b0, 1'b1);
    step();
    check_output("swap_w_swap_out", w_swap_out, 1);
    apply_stimulus(1'b1, 16'sd5, 40'sd10, 16'sd0, 1'b0, 1'b0);
    step();
    check_output("fwd_out_data", out_data, 5);
    check_output("fwd_out_data_valid", out_data_valid, 1);
    check_output("mac_lat1_valid", out_sum_valid, 0);
    apply_stimulus(1'b0, 16'sd0, 40'sd0, 16'sd0, 1'b0, 1'b0);
    step();
    check_output("mac_lat2_valid", out_sum_valid, 0);
    check_output("bubble_out_data_valid", out_data_valid, 0);
    step();
    check_output("mac_lat3_valid", out_sum_valid, 1);
    check_output("mac_lat3_sum", out_sum, 25);
    step();
    check_output("mac_after_valid", out_sum_valid, 0);
    check_output("mac_hold_sum", out_sum, 25);

    // Back-to-back accepts with a swap 2 -> -4 in the first accept's cycle
    apply_stimulus(1'b0, 16'sd0, 40'sd0, 16'sd2, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 16'sd0, 40'sd0, 16'sd0, 1'b0, 1'b1);
    step();
    apply_stimulus(1'b0, 16'sd0, 40'sd0, -16'sd4, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b1, 16'sd7, 40'sd0, 16'sd0, 1'b0, 1'b1);
    step();
    apply_stimulus(1'b1, 16'sd7, 40'sd0, 16'sd0, 1'b0, 1'b0);
    step();
    apply_stimulus(1'b0, 16'sd0, 40'sd0, 16'sd0, 1'b0, 1'b0);
    step();
    check_output("b2b_first_valid", out_sum_valid, 1);
    check_output("b2b_first_sum", out_sum, 14);
    step();
    check_output("b2b_second_valid", out_sum_valid, 1);
    check_output("b2b_second_sum", out_sum, -28);

    // Freeze mid-pipeline: 3*-4+100 = 88 after three enabled cycles
    apply_stimulus(1'b1, 16'sd3, 40'sd100, 16'sd0, 1'b0, 1'b0);
    step();
    apply_stimulus(1'b0, 16'sd3, 40'sd0, 16'sd0, 1'b0, 1'b0);
    step();
    enable = 1'b0;
    apply_stimulus(1'b1, 16'sd55, 40'sd1, 16'sd11, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step();
    check_output("freeze_sum_valid", out_sum_valid, 0);
    check_output("freeze_sum_hold", out_sum, -28);
    check_output("freeze_out_data", out_data, 3);
    check_output("freeze_out_data_valid", out_data_valid, 0);
    check_output("freeze_w_out", w_out, -4);
    enable = 1'b1;
    apply_stimulus(1'b0, 16'sd0, 40'sd0, 16'sd0, 1'b0, 1'b0);
    step();
    check_output("freeze_result_valid", out_sum_valid, 1);
    check_output("freeze_result_sum", out_sum, 88);

    // Same-cycle load 9 and swap with shadow 1, then overflow and new-weight MACs
    apply_stimulus(1'b0, 16'sd0, 40'sd0, 16'sd1, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 16'sd0, 40'sd0, 16'sd9, 1'b1, 1'b1);
    step();
    check_output("ldswap_w_out", w_out, 9);
    check_output("ldswap_w_swap_out", w_swap_out, 1);
    check_output("ldswap_w_load_out", w_load_out, 1);
    apply_stimulus(1'b1, 16'sd6, 40'sd0, 16'sd0, 1'b0, 1'b0);
    step();
    check_output("ldswap_w_swap_out_clear", w_swap_out, 0);
    apply_stimulus(1'b1, 16'sd1, 40'sh7F_FFFF_FFFF, 16'sd0, 1'b0, 1'b1);
    step();
    apply_stimulus(1'b1, 16'sd2, 40'sd1, 16'sd0, 1'b0, 1'b0);
    step();
    check_output("active_old_shadow_sum", out_sum, 6);
    apply_stimulus(1'b0, 16'sd0, 40'sd0, 16'sd0, 1'b0, 1'b0);
    step();
    check_output("overflow_sum", out_sum, OVF_EXP);
    step();
    check_output("new_weight_sum", out_sum, 19);
    check_output("new_weight_valid", out_sum_valid, 1);

    // Asynchronous reset between edges with two MACs in flight
    apply_stimulus(1'b1, 16'sd1, 40'sd5, 16'sd0, 1'b0, 1'b0);
    step();
    step();
    apply_stimulus(1'b0, 16'sd0, 40'sd0, 16'sd0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async_rst_out_sum", out_sum, 0);
    check_output("async_rst_sum_valid", out_sum_valid, 0);
    check_output("async_rst_data_valid", out_data_valid, 0);
    check_output("async_rst_w_out", w_out, 0);
    #2;
    reset_n = 1'b1;
    apply_stimulus(1'b1, 16'sd5, 40'sd77, 16'sd0, 1'b0, 1'b0);
    step();
    check_output("post_rst_valid_e1", out_sum_valid, 0);
    apply_stimulus(1'b0, 16'sd0, 40'sd0, 16'sd0, 1'b0, 1'b0);
    step();
    check_output("post_rst_valid_e2", out_sum_valid, 0);
    step();
    check_output("post_rst_first_accept_valid", out_sum_valid, 1);
    check_output("post_rst_first_accept_sum", out_sum, 77);
    step();
    check_output("post_rst_no_stale", out_sum_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
